fp32_unpack_normalizer: RTL

- Decoder-side counterpart to the IEEE-754 single-precision adder. The adder packs sign, exponent and fraction into a 32-bit word; this block takes a packed word apart.
- Accepts one packed fp32 word over a valid/ready handshake, classifies it, and outputs sign, unbiased signed exponent and a normalized 24-bit significand with the hidden bit explicit.
- Subnormals are normalized iteratively, one left shift per cycle.
- Sits upstream of multi-cycle arithmetic and checkers that need operands in unpacked form.

---
 rtl/fp32_unpack_normalizer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fp32_unpack_normalizer.sv
// fp32_unpack_normalizer: splits a packed IEEE-754 single into sign, unbiased
// signed exponent and explicit-hidden-bit significand, classifies it, and
// normalizes subnormals one left shift per cycle.
// Optional build macro: FP32_UNPACK_DAZ_EN (denormals-are-zero; subnormals are
// emitted as zero with a two-hot "flushed" class marker, NORM never entered).
module fp32_unpack_normalizer #(
    parameter int unsigned EXP_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [23:0]      out_mant,
    output logic [4:0]       out_class,
    output logic             out_snan,
    output logic [4:0]       out_shift
);

    localparam int unsigned BIAS = 127;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic             accept;
    logic [7:0]       e_fld;
    logic [22:0]      f_fld;
    logic [EXP_W-1:0] dec_exp;
    logic [23:0]      dec_mant;
    logic [4:0]       dec_class;
    logic             dec_snan;
    logic             dec_sub;

    // Ready when idle, or when the held result is leaving this same edge
    assign in_ready = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    // Field decode and classification of the incoming word
    always_comb begin
        e_fld     = in_data[30:23];
        f_fld     = in_data[22:0];
        dec_exp   = '0;
        dec_mant  = '0;
        dec_class = '0;
        dec_snan  = 1'b0;
        dec_sub   = 1'b0;
        if (e_fld == 8'hFF) begin
            dec_exp  = EXP_W'(128);
            dec_mant = {1'b1, f_fld};
            if (f_fld == 23'd0) begin
                dec_class = 5'b01000;
            end else begin
                dec_class = 5'b10000;
                dec_snan  = ~f_fld[22];
            end
        end else if (e_fld != 8'd0) begin
            dec_exp   = EXP_W'(e_fld) - EXP_W'(BIAS);
            dec_mant  = {1'b1, f_fld};
            dec_class = 5'b00100;
        end else if (f_fld == 23'd0) begin
            dec_class = 5'b00001;
        end else begin
`ifdef FP32_UNPACK_DAZ_EN
            // Flushed subnormal: reported as zero plus the subnormal marker
            dec_class = 5'b00011;
`else
            dec_exp   = EXP_W'(0) - EXP_W'(BIAS - 1);
            dec_mant  = {1'b0, f_fld};
            dec_class = 5'b00010;
            dec_sub   = 1'b1;
`endif
        end
    end

    // Control state and registered result; loads on acceptance, shifts in NORM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_mant  <= '0;
            out_class <= '0;
            out_snan  <= 1'b0;
            out_shift <= '0;
        end else if (accept) begin
            out_sign  <= in_data[31];
            out_exp   <= dec_exp;
            out_mant  <= dec_mant;
            out_class <= dec_class;
            out_snan  <= dec_snan;
            out_shift <= '0;
            state     <= dec_sub ? NORM : DONE;
            out_valid <= ~dec_sub;
        end else begin
            case (state)
                NORM: begin
                    out_mant  <= {out_mant[22:0], 1'b0};
                    out_exp   <= out_exp - EXP_W'(1);
                    out_shift <= out_shift + 5'd1;
                    if (out_mant[22]) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
